// File: rtl/micro_core_if.sv
// micro_core_if: instruction-fetch handshake and status/write-back bus of micro_core.
//
// Signals:
//   instr_valid          core <- ROM   instruction holds a valid word for instruction_address
//   instruction          core <- ROM   fetched instruction word (IW bits)
//   instr_req            core -> ROM   fetch request, high exactly while fetching
//   instruction_address  core -> ROM   current program counter
//   op                   core -> out   opcode of the latched instruction
//   mem_read/mem_write   core -> out   one-cycle strobes while executing LOAD / STORE
//   reg_write            core -> out   one-cycle strobe while executing ADD or LOAD
//   wb_reg/wb_data       core -> out   destination and value of the last register write
//   wb_valid             core -> out   last retired instruction wrote a register
//   halted               core -> out   core stopped after a branch-to-self
//
// The master modport is the core side; the slave modport is the ROM/console side.
interface micro_core_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int REG_ADDR_BITS = 2,
    parameter int PC_WIDTH      = 8
);
    localparam int IW = 2 + 3 * REG_ADDR_BITS;

    logic                     instr_valid;
    logic [IW-1:0]            instruction;
    logic                     instr_req;
    logic [PC_WIDTH-1:0]      instruction_address;
    logic [1:0]               op;
    logic                     mem_read;
    logic                     mem_write;
    logic                     reg_write;
    logic [REG_ADDR_BITS-1:0] wb_reg;
    logic [DATA_WIDTH-1:0]    wb_data;
    logic                     wb_valid;
    logic                     halted;

    modport master (
        input  instr_valid, instruction,
        output instr_req, instruction_address, op, mem_read, mem_write,
               reg_write, wb_reg, wb_data, wb_valid, halted
    );

    modport slave (
        output instr_valid, instruction,
        input  instr_req, instruction_address, op, mem_read, mem_write,
               reg_write, wb_reg, wb_data, wb_valid, halted
    );
endinterface

// File: rtl/micro_core.sv
// micro_core: parametrised four-opcode processor (ADD, LOAD, STORE, BRANCH) with a
// FETCH/EXEC/HALT control FSM. FETCH waits (unbounded) for instr_valid, EXEC retires
// the latched instruction in one cycle, HALT is entered on a branch-to-self and left
// only through reset.
//
// Ports:
//   clock  in   core clock, rising edge
//   reset  in   asynchronous, active-high; clears pc, ir, registers, wb state and
//               reloads the data memory with its power-on pattern
//   bus    master side of micro_core_if (fetch handshake, strobes, write-back, halted)
//
// Instruction word, MSB first: op[1:0], rs, rt, f (each REG_ADDR_BITS wide).
module micro_core #(
    parameter int DATA_WIDTH    = 8,
    parameter int REG_ADDR_BITS = 2,
    parameter int MEM_ADDR_BITS = 5,
    parameter int PC_WIDTH      = 8
) (
    input  logic          clock,
    input  logic          reset,
    micro_core_if.master  bus
);
    localparam int IW        = 2 + 3 * REG_ADDR_BITS;
    localparam int NUM_REGS  = 1 << REG_ADDR_BITS;
    localparam int MEM_DEPTH = 1 << MEM_ADDR_BITS;

    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_LOAD   = 2'b01;
    localparam logic [1:0] OP_STORE  = 2'b10;
    localparam logic [1:0] OP_BRANCH = 2'b11;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    // Power-on memory pattern: lower half counts up from 0, upper half counts down
    // from 0 (M[half] = 0, M[half+1] = -1, ...).
    function automatic logic [DATA_WIDTH-1:0] mem_init(input logic [MEM_ADDR_BITS-1:0] idx);
        logic [DATA_WIDTH-1:0] v_lo;
        v_lo = DATA_WIDTH'({1'b0, idx[MEM_ADDR_BITS-2:0]});
        return idx[MEM_ADDR_BITS-1] ? (~v_lo + 1'b1) : v_lo;
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] sext_data(input logic [REG_ADDR_BITS-1:0] f);
        return {{(DATA_WIDTH-REG_ADDR_BITS){f[REG_ADDR_BITS-1]}}, f};
    endfunction

    function automatic logic signed [PC_WIDTH-1:0] sext_pc(input logic [REG_ADDR_BITS-1:0] f);
        return {{(PC_WIDTH-REG_ADDR_BITS){f[REG_ADDR_BITS-1]}}, f};
    endfunction

    state_t                   r_state;
    state_t                   w_state_next;
    logic [PC_WIDTH-1:0]      r_pc;
    logic [IW-1:0]            r_ir;
    logic [DATA_WIDTH-1:0]    r_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0]    r_mem  [MEM_DEPTH];
    logic [REG_ADDR_BITS-1:0] r_wb_reg;
    logic [DATA_WIDTH-1:0]    r_wb_data;
    logic                     r_wb_valid;

    logic [1:0]                   w_op;
    logic [REG_ADDR_BITS-1:0]     w_rs;
    logic [REG_ADDR_BITS-1:0]     w_rt;
    logic [REG_ADDR_BITS-1:0]     w_f;
    logic signed [DATA_WIDTH-1:0] w_imm_d;
    logic signed [PC_WIDTH-1:0]   w_imm_p;
    logic [DATA_WIDTH-1:0]        w_rs_val;
    logic [DATA_WIDTH-1:0]        w_rt_val;
    logic [DATA_WIDTH-1:0]        w_add;
    logic [MEM_ADDR_BITS-1:0]     w_addr;
    logic [PC_WIDTH-1:0]          w_pc_inc;
    logic [PC_WIDTH-1:0]          w_br_tgt;
    logic                         w_self_branch;
    logic                         w_exec;
    logic                         w_fetch_take;

    // Decode of the latched instruction
    assign w_op     = r_ir[IW-1 -: 2];
    assign w_rs     = r_ir[3*REG_ADDR_BITS-1 -: REG_ADDR_BITS];
    assign w_rt     = r_ir[2*REG_ADDR_BITS-1 -: REG_ADDR_BITS];
    assign w_f      = r_ir[REG_ADDR_BITS-1:0];
    assign w_imm_d  = sext_data(w_f);
    assign w_imm_p  = sext_pc(w_f);

    // Operands come from the pre-edge register file, so ADD with f == rs sees old R[rs]
    assign w_rs_val = r_regs[w_rs];
    assign w_rt_val = r_regs[w_rt];
    assign w_add    = w_rs_val + w_rt_val;
    // Effective address keeps only the low MEM_ADDR_BITS, so negative offsets wrap
    assign w_addr   = MEM_ADDR_BITS'(w_rs_val + $unsigned(w_imm_d));

    assign w_pc_inc = r_pc + PC_WIDTH'(1);
    assign w_br_tgt = w_pc_inc + $unsigned(w_imm_p);
    // imm == -1 means the target is the branch itself
    assign w_self_branch = &w_f;

    assign w_exec       = (r_state == S_EXEC);
    assign w_fetch_take = (r_state == S_FETCH) && bus.instr_valid;

    assign bus.instr_req           = (r_state == S_FETCH);
    assign bus.halted              = (r_state == S_HALT);
    assign bus.instruction_address = r_pc;
    assign bus.op                  = w_op;
    assign bus.mem_read            = w_exec && (w_op == OP_LOAD);
    assign bus.mem_write           = w_exec && (w_op == OP_STORE);
    assign bus.reg_write           = w_exec && ((w_op == OP_ADD) || (w_op == OP_LOAD));
    assign bus.wb_reg              = r_wb_reg;
    assign bus.wb_data             = r_wb_data;
    assign bus.wb_valid            = r_wb_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (bus.instr_valid) begin
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if ((w_op == OP_BRANCH) && w_self_branch) begin
                    w_state_next = S_HALT;
                end else begin
                    w_state_next = S_FETCH;
                end
            end
            S_HALT:  w_state_next = S_HALT;
            default: w_state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc       <= '0;
            r_ir       <= '0;
            r_wb_reg   <= '0;
            r_wb_data  <= '0;
            r_wb_valid <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[REG_ADDR_BITS'(i)] <= '0;
            end
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[MEM_ADDR_BITS'(i)] <= mem_init(MEM_ADDR_BITS'(i));
            end
        end else begin
            if (w_fetch_take) begin
                r_ir <= bus.instruction;
            end
            if (w_exec) begin
                case (w_op)
                    OP_ADD: begin
                        r_regs[w_f] <= w_add;
                        r_wb_reg    <= w_f;
                        r_wb_data   <= w_add;
                        r_wb_valid  <= 1'b1;
                        r_pc        <= w_pc_inc;
                    end
                    OP_LOAD: begin
                        r_regs[w_rt] <= r_mem[w_addr];
                        r_wb_reg     <= w_rt;
                        r_wb_data    <= r_mem[w_addr];
                        r_wb_valid   <= 1'b1;
                        r_pc         <= w_pc_inc;
                    end
                    OP_STORE: begin
                        r_mem[w_addr] <= w_rt_val;
                        r_wb_valid    <= 1'b0;
                        r_pc          <= w_pc_inc;
                    end
                    default: begin
                        r_wb_valid <= 1'b0;
                        r_pc       <= w_br_tgt;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_micro_core.sv
// tb_micro_core: directed plus randomized program for micro_core, compared against an
// instruction-level reference model (architectural pc, register file, memory, wb state).
module tb_micro_core;
    localparam int DW = 8;
    localparam int RB = 2;
    localparam int MB = 5;
    localparam int PW = 8;
    localparam int NR = 4;
    localparam int MD = 32;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    micro_core_if #(.DATA_WIDTH(DW), .REG_ADDR_BITS(RB), .PC_WIDTH(PW)) bus ();

    micro_core #(.DATA_WIDTH(DW), .REG_ADDR_BITS(RB), .MEM_ADDR_BITS(MB), .PC_WIDTH(PW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int m_pc;
    int m_R [NR];
    int m_M [MD];
    int m_wbv, m_wbr, m_wbd, m_halt;

    function automatic int wrap(input int x, input int m);
        return ((x % m) + m) % m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_wbv = 0; m_wbr = 0; m_wbd = 0; m_halt = 0;
        for (int i = 0; i < NR; i++) m_R[i] = 0;
        for (int i = 0; i < MD; i++) m_M[i] = (i < MD/2) ? i : wrap(-(i - MD/2), 256);
    endtask

    task automatic model_exec(input logic [7:0] w);
        int op, rs, rt, f, imm, a;
        op  = int'(w[7:6]);
        rs  = int'(w[5:4]);
        rt  = int'(w[3:2]);
        f   = int'(w[1:0]);
        imm = (f >= 2) ? f - 4 : f;
        a   = wrap(m_R[rs] + imm, MD);
        case (op)
            0: begin
                m_R[f] = (m_R[rs] + m_R[rt]) % 256;
                m_wbv = 1; m_wbr = f; m_wbd = m_R[f];
                m_pc = (m_pc + 1) % 256;
            end
            1: begin
                m_R[rt] = m_M[a];
                m_wbv = 1; m_wbr = rt; m_wbd = m_R[rt];
                m_pc = (m_pc + 1) % 256;
            end
            2: begin
                m_M[a] = m_R[rt];
                m_wbv = 0;
                m_pc = (m_pc + 1) % 256;
            end
            default: begin
                m_wbv = 0;
                if (imm == -1) m_halt = 1;
                m_pc = wrap(m_pc + 1 + imm, 256);
            end
        endcase
    endtask

    task automatic check_state(input string ctx);
        chk({ctx, "_pc"},       32'(bus.instruction_address), 32'(m_pc));
        chk({ctx, "_wb_valid"}, 32'(bus.wb_valid),            32'(m_wbv));
        chk({ctx, "_wb_reg"},   32'(bus.wb_reg),              32'(m_wbr));
        chk({ctx, "_wb_data"},  32'(bus.wb_data),             32'(m_wbd));
        chk({ctx, "_halted"},   32'(bus.halted),              32'(m_halt));
        chk({ctx, "_instr_req"}, 32'(bus.instr_req),          32'(m_halt == 0));
        for (int i = 0; i < NR; i++)
            chk($sformatf("%s_R%0d", ctx, i), 32'(dut.r_regs[i]), 32'(m_R[i]));
        for (int i = 0; i < MD; i++)
            chk($sformatf("%s_M%0d", ctx, i), 32'(dut.r_mem[i]), 32'(m_M[i]));
    endtask

    // Presents w after `waits` idle FETCH cycles, checks EXEC strobes, then retires it.
    task automatic run_instr(input logic [7:0] w, input int waits);
        int op;
        op = int'(w[7:6]);
        for (int k = 0; k < waits; k++) begin
            bus.instr_valid = 1'b0;
            bus.instruction = 8'($urandom);
            @(posedge clock); #1;
            chk("wait_pc",      32'(bus.instruction_address), 32'(m_pc));
            chk("wait_strobes", 32'({bus.mem_read, bus.mem_write, bus.reg_write}), 32'd0);
            chk("wait_req",     32'(bus.instr_req), 32'd1);
            chk("wait_wbv",     32'(bus.wb_valid),  32'(m_wbv));
        end
        bus.instr_valid = 1'b1;
        bus.instruction = w;
        @(posedge clock); #1;
        // Inputs outside FETCH must be ignored
        bus.instr_valid = 1'($urandom);
        bus.instruction = 8'($urandom);
        chk("exec_op",  32'(bus.op), 32'(op));
        chk("exec_strobes", 32'({bus.mem_read, bus.mem_write, bus.reg_write}),
            32'({op == 1, op == 2, op < 2}));
        chk("exec_req", 32'(bus.instr_req), 32'd0);
        @(posedge clock); #1;
        bus.instr_valid = 1'b0;
        model_exec(w);
        check_state($sformatf("ret%02h", w));
    endtask

    initial begin
        logic [7:0] w;
        reset = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instruction = '0;
        #12;
        reset = 1'b0;
        model_reset();
        check_state("reset");
        chk("reset_M17", 32'(dut.r_mem[17]), 32'h0000_00FF);
        chk("reset_M31", 32'(dut.r_mem[31]), 32'h0000_00F1);
        chk("reset_op",  32'(bus.op), 32'd0);

        run_instr(8'h45, 0);
        chk("load1_wb", 32'({bus.wb_reg, bus.wb_data}), 32'h0000_0101);
        run_instr(8'h4B, 1);
        chk("load2_wb", 32'({bus.wb_reg, bus.wb_data}), 32'h0000_02F1);
        chk("load2_pc", 32'(bus.instruction_address), 32'd2);
        run_instr(8'h1B, 0);
        chk("add_wb", 32'({bus.wb_valid, bus.wb_reg, bus.wb_data}), 32'h0000_07F2);
        run_instr(8'h9C, 0);
        chk("store_wbv", 32'(bus.wb_valid), 32'd0);
        chk("store_M1",  32'(dut.r_mem[1]), 32'h0000_00F2);
        run_instr(8'h50, 5);
        chk("load_R0", 32'(dut.r_regs[0]), 32'h0000_00F2);

        // Build R3 = 0xFF (from M[17]) and R1 = 1, then add: carry must drop
        run_instr(8'h16, 0);
        run_instr(8'h2A, 2);
        run_instr(8'h2A, 0);
        run_instr(8'h2A, 1);
        run_instr(8'h6D, 0);
        chk("ff_R3", 32'(dut.r_regs[3]), 32'h0000_00FF);
        run_instr(8'h34, 0);
        chk("carry_wb", 32'({bus.wb_valid, bus.wb_data}), 32'h0000_0100);

        for (int n = 0; n < 60; n++) begin
            w = 8'($urandom_range(0, 255));
            if (w[7:6] == 2'b11 && w[1:0] == 2'b11) w[1:0] = 2'b00;
            run_instr(w, int'($urandom_range(0, 3)));
        end

        // Reset asserted mid-EXEC of a STORE discards the write
        bus.instr_valid = 1'b1;
        bus.instruction = 8'h9C;
        @(posedge clock); #1;
        bus.instr_valid = 1'b0;
        chk("mid_exec_wr", 32'(bus.mem_write), 32'd1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_state("rst_exec");
        #2 reset = 1'b0;

        for (int n = 0; n < 4; n++) run_instr(8'h00, 0);
        chk("pre_br_pc", 32'(bus.instruction_address), 32'd4);
        run_instr(8'hC1, 0);
        chk("br_pc", 32'(bus.instruction_address), 32'd6);
        run_instr(8'hC3, 0);
        for (int k = 0; k < 10; k++) begin
            bus.instr_valid = 1'($urandom);
            bus.instruction = 8'($urandom);
            @(posedge clock); #1;
            chk("halt_state", 32'({bus.halted, bus.instr_req}), 32'h2);
            chk("halt_pc",    32'(bus.instruction_address), 32'd6);
            chk("halt_strobes", 32'({bus.mem_read, bus.mem_write, bus.reg_write}), 32'd0);
        end
        bus.instr_valid = 1'b0;
        #3 reset = 1'b1;
        #1;
        model_reset();
        chk("halt_rst_pc",     32'(bus.instruction_address), 32'd0);
        chk("halt_rst_halted", 32'(bus.halted), 32'd0);
        #2 reset = 1'b0;

        run_instr(8'hC2, 0);
        chk("back_pc", 32'(bus.instruction_address), 32'h0000_00FF);
        run_instr(8'h00, 1);
        chk("wrap_pc", 32'(bus.instruction_address), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
